// File: rtl/prog_sequencer_pkg.sv
// Shared definitions for the program sequencer: instruction layout, ALU opcodes,
// and the sequencer state encoding.
package prog_sequencer_pkg;

    // Instruction word {op[2:0], rd[3:0], rs[3:0], rt[3:0]}
    localparam int unsigned INSTR_W = 15;
    localparam int unsigned OP_W    = 3;
    localparam int unsigned REG_W   = 4;
    localparam int unsigned OP_LSB  = 12;
    localparam int unsigned RD_LSB  = 8;
    localparam int unsigned RS_LSB  = 4;
    localparam int unsigned RT_LSB  = 0;

    // ALU opcodes understood by the master
    localparam logic [OP_W-1:0] OP_ADD = 3'd0;
    localparam logic [OP_W-1:0] OP_SUB = 3'd1;
    localparam logic [OP_W-1:0] OP_AND = 3'd2;
    localparam logic [OP_W-1:0] OP_OR  = 3'd3;
    localparam logic [OP_W-1:0] OP_XOR = 3'd4;
    localparam logic [OP_W-1:0] OP_SL  = 3'd5;
    localparam logic [OP_W-1:0] OP_SR  = 3'd6;
    localparam logic [OP_W-1:0] OP_SLT = 3'd7;

    // Sequencer states; explicit values keep the legacy 3-bit encoding
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SETUP     = 3'd1,
        ST_PULSE     = 3'd2,
        ST_SETTLE_LO = 3'd3,
        ST_SETTLE_HI = 3'd4,
        ST_EMIT      = 3'd5,
        ST_DONE      = 3'd6
    } seq_state_e;

    // Assemble an instruction word from its fields
    function automatic logic [INSTR_W-1:0] make_instr(
        input logic [OP_W-1:0]  op,
        input logic [REG_W-1:0] rd,
        input logic [REG_W-1:0] rs,
        input logic [REG_W-1:0] rt
    );
        return {op, rd, rs, rt};
    endfunction

endpackage

// File: rtl/prog_sequencer_mem.sv
// Program memory for the sequencer: one synchronous write port, one asynchronous
// read port. Contents are deliberately not reset so a program survives a reset.
module seq_prog_mem
    import prog_sequencer_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               we_i,
    input  logic [AW-1:0]      waddr_i,
    input  logic [INSTR_W-1:0] wdata_i,
    input  logic [AW-1:0]      raddr_i,
    output logic [INSTR_W-1:0] rdata_o
);

    logic [INSTR_W-1:0] mem_q [DEPTH];

    // Write port: store the instruction word on the strobe
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/prog_sequencer.sv
// Replays a loaded program onto the master's sw/btn_exec interface, reads the
// 32-bit result back through led in two halves and offers it on a valid/ready port.
module prog_sequencer
    import prog_sequencer_pkg::*;
#(
    parameter int unsigned PROG_DEPTH = 16,
    parameter int unsigned SETUP_CYC  = 4,
    parameter int unsigned PULSE_CYC  = 2,
    parameter int unsigned SETTLE_CYC = 4,
    localparam int unsigned AW        = $clog2(PROG_DEPTH)
) (
    input  logic               clk,
    input  logic               btn_reset_n,
    input  logic               prog_we,
    input  logic [AW-1:0]      prog_addr,
    input  logic [INSTR_W-1:0] prog_data,
    input  logic [AW:0]        prog_len,
    input  logic               start,
    output logic [15:0]        sw,
    output logic               btn_exec,
    input  logic [15:0]        led,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [31:0]        res_data,
    output logic [AW-1:0]      res_idx,
    output logic               busy,
    output logic               done
);

    localparam int unsigned      CNT_W     = 16;
    localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] PULSE_LD  = CNT_W'(PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYC - 1);
    localparam logic [AW:0]      DEPTH_L   = (AW+1)'(PROG_DEPTH);

    seq_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]      idx_q, idx_d;
    logic [AW:0]        len_q, len_d;
    logic [15:0]        lo_q, lo_d;
    logic [15:0]        sw_q, sw_d;
    logic               btn_q, btn_d;
    logic               res_valid_q, res_valid_d;
    logic [31:0]        res_data_q, res_data_d;
    logic [AW-1:0]      res_idx_q, res_idx_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [AW:0]        len_sat;
    logic [AW:0]        idx_inc;
    logic [AW-1:0]      mem_raddr;
    logic [INSTR_W-1:0] mem_rdata;
    logic               mem_we;

    // Program memory; writes are only honoured while no run is in progress
    assign mem_we = prog_we && !busy_q;

    seq_prog_mem #(
        .DEPTH (PROG_DEPTH)
    ) u_mem (
        .clk     (clk),
        .we_i    (mem_we),
        .waddr_i (prog_addr),
        .wdata_i (prog_data),
        .raddr_i (mem_raddr),
        .rdata_o (mem_rdata)
    );

    // Length clamp and read-address selection (entry 0 on start, idx+1 when advancing)
    always_comb begin
        len_sat   = (prog_len > DEPTH_L) ? DEPTH_L : prog_len;
        idx_inc   = {1'b0, idx_q} + (AW+1)'(1);
        mem_raddr = (state_q == ST_EMIT) ? idx_inc[AW-1:0] : '0;
    end

    // Next-state logic: FSM, shared timing counter, index and result registers
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        len_d       = len_q;
        lo_d        = lo_q;
        sw_d        = sw_q;
        btn_d       = btn_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_idx_d   = res_idx_q;
        busy_d      = busy_q;
        done_d      = done_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    len_d  = len_sat;
                    idx_d  = '0;
                    done_d = 1'b0;
                    if (len_sat == '0) begin
                        // Empty program: finish straight away without touching the master
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        busy_d  = 1'b1;
                        sw_d    = {1'b0, mem_rdata};
                        cnt_d   = SETUP_LD;
                        state_d = ST_SETUP;
                    end
                end
            end
            ST_SETUP: begin
                if (cnt_q == '0) begin
                    btn_d   = 1'b1;
                    cnt_d   = PULSE_LD;
                    state_d = ST_PULSE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_PULSE: begin
                if (cnt_q == '0) begin
                    btn_d   = 1'b0;
                    cnt_d   = SETTLE_LD;
                    state_d = ST_SETTLE_LO;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_SETTLE_LO: begin
                if (cnt_q == '0) begin
                    lo_d    = led;
                    sw_d    = {1'b1, sw_q[14:0]};
                    cnt_d   = SETTLE_LD;
                    state_d = ST_SETTLE_HI;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_SETTLE_HI: begin
                if (cnt_q == '0) begin
                    res_data_d  = {led, lo_q};
                    res_idx_d   = idx_q;
                    res_valid_d = 1'b1;
                    state_d     = ST_EMIT;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_EMIT: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    if (idx_inc == len_q) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = idx_inc[AW-1:0];
                        sw_d    = {1'b0, mem_rdata};
                        cnt_d   = SETUP_LD;
                        state_d = ST_SETUP;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge btn_reset_n) begin
        if (!btn_reset_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            len_q       <= '0;
            lo_q        <= '0;
            sw_q        <= '0;
            btn_q       <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_idx_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            len_q       <= len_d;
            lo_q        <= lo_d;
            sw_q        <= sw_d;
            btn_q       <= btn_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_idx_q   <= res_idx_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign sw        = sw_q;
    assign btn_exec  = btn_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_idx   = res_idx_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_prog_sequencer.sv
// Bench for prog_sequencer with a small behavioural master (16x32 regfile, R[i]=i on
// reset) answering sw/btn_exec through led. Expected results are queued when a run
// is issued; a monitor pops and compares them on every accepted result.
module tb_prog_sequencer;
    import prog_sequencer_pkg::*;

    localparam int unsigned DEPTH  = 16;
    localparam int unsigned AW     = 4;
    localparam int unsigned SETUP  = 4;
    localparam int unsigned PULSE  = 2;
    localparam int unsigned SETTLE = 4;

    logic               clk = 1'b0;
    logic               btn_reset_n = 1'b0;
    logic               prog_we = 1'b0;
    logic [AW-1:0]      prog_addr = '0;
    logic [INSTR_W-1:0] prog_data = '0;
    logic [AW:0]        prog_len = '0;
    logic               start = 1'b0;
    logic [15:0]        sw;
    logic               btn_exec;
    logic [15:0]        led;
    logic               res_valid;
    logic               res_ready = 1'b1;
    logic [31:0]        res_data;
    logic [AW-1:0]      res_idx;
    logic               busy;
    logic               done;

    prog_sequencer #(
        .PROG_DEPTH (DEPTH),
        .SETUP_CYC  (SETUP),
        .PULSE_CYC  (PULSE),
        .SETTLE_CYC (SETTLE)
    ) dut (
        .clk         (clk),
        .btn_reset_n (btn_reset_n),
        .prog_we     (prog_we),
        .prog_addr   (prog_addr),
        .prog_data   (prog_data),
        .prog_len    (prog_len),
        .start       (start),
        .sw          (sw),
        .btn_exec    (btn_exec),
        .led         (led),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
        .res_idx     (res_idx),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    // ---------------- master model ----------------
    logic [31:0] regs [16];
    logic [31:0] mres;
    logic        mbtn_prev;

    function automatic logic [31:0] alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_SL:   return a << b[4:0];
            OP_SR:   return a >> b[4:0];
            default: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        endcase
    endfunction

    always @(posedge clk or negedge btn_reset_n) begin
        if (!btn_reset_n) begin
            for (int i = 0; i < 16; i++) regs[i] <= 32'(i);
            mres      <= '0;
            mbtn_prev <= 1'b0;
        end else begin
            mbtn_prev <= btn_exec;
            if (btn_exec && !mbtn_prev) begin
                mres           <= alu(sw[14:12], regs[sw[7:4]], regs[sw[3:0]]);
                regs[sw[11:8]] <= alu(sw[14:12], regs[sw[7:4]], regs[sw[3:0]]);
            end
        end
    end

    assign led = sw[15] ? mres[31:16] : mres[15:0];

    // ---------------- checking ----------------
    typedef struct packed {
        logic [AW-1:0] idx;
        logic [31:0]   data;
    } exp_t;

    exp_t sb [$];
    exp_t e;
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    // Protocol observations, sampled on the falling edge
    int          cyc = 0, sw_chg_cyc = 0, sw15_cyc = 0, btn_rise_cyc = 0, btn_fall_cyc = 0, valid_cyc = 0;
    int          btn_rises = 0, valid_rises = 0, viol = 0;
    logic [15:0] sw_prev = '0;
    logic        btn_prev = 1'b0, valid_prev = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (sw[14:0] != sw_prev[14:0]) sw_chg_cyc = cyc;
        if (sw[15] && !sw_prev[15]) sw15_cyc = cyc;
        if (btn_exec && (sw != sw_prev)) viol++;
        if (btn_exec && !btn_prev) begin btn_rise_cyc = cyc; btn_rises++; end
        if (!btn_exec && btn_prev) btn_fall_cyc = cyc;
        if (res_valid && !valid_prev) begin valid_cyc = cyc; valid_rises++; end
        sw_prev    = sw;
        btn_prev   = btn_exec;
        valid_prev = res_valid;
        if (btn_reset_n && res_valid && res_ready) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_result: got idx=%0d data=%h required none", res_idx, res_data);
            end else begin
                e = sb.pop_front();
                check("res_data", res_data, e.data);
                check("res_idx", 32'(res_idx), 32'(e.idx));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic load(input logic [AW-1:0] a, input logic [INSTR_W-1:0] d);
        @(negedge clk);
        prog_we = 1'b1; prog_addr = a; prog_data = d;
        @(negedge clk);
        prog_we = 1'b0;
    endtask

    task automatic run(input logic [AW:0] len);
        @(negedge clk);
        start = 1'b1; prog_len = len;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic push(input logic [AW-1:0] idx, input logic [31:0] data);
        exp_t x;
        x.idx = idx; x.data = data;
        sb.push_back(x);
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        while (!done && k < budget) begin @(negedge clk); k++; end
        check("run_done", 32'(done), 32'd1);
    endtask

    task automatic pulse_reset();
        @(negedge clk); #2 btn_reset_n = 1'b0;
        @(negedge clk); #2 btn_reset_n = 1'b1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout required completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
        $fatal(1, "watchdog");
    end

    int          bt0, v0, k;
    logic [31:0] d0;
    logic [15:0] s0;
    logic        stable;

    initial begin
        // Reset state
        #12;
        check("rst_sw", 32'(sw), 32'd0);
        check("rst_btn", 32'(btn_exec), 32'd0);
        check("rst_valid", 32'(res_valid), 32'd0);
        check("rst_data", res_data, 32'd0);
        check("rst_idx", 32'(res_idx), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        @(negedge clk); #2 btn_reset_n = 1'b1;

        // 1/2: single ADD R4=R1+R2 and its handshake timing
        load(4'd0, 15'b000_0100_0001_0010);
        push(4'd0, 32'h0000_0003);
        bt0 = btn_rises;
        run(5'd1);
        wait_done(200);
        check("t1_busy", 32'(busy), 32'd0);
        check("t1_btn_count", 32'(btn_rises - bt0), 32'd1);
        check("t2_setup", 32'(btn_rise_cyc - sw_chg_cyc), 32'(SETUP));
        check("t2_pulse", 32'(btn_fall_cyc - btn_rise_cyc), 32'(PULSE));
        check("t2_lo_settle", 32'(sw15_cyc - btn_fall_cyc), 32'(SETTLE));
        check("t2_hi_settle", 32'(valid_cyc - sw15_cyc), 32'(SETTLE));

        // 3: four-instruction program, consumer always ready
        load(4'd0, make_instr(OP_ADD, 4'd4, 4'd1, 4'd2));
        load(4'd1, make_instr(OP_SUB, 4'd5, 4'd11, 4'd10));
        load(4'd2, make_instr(OP_SLT, 4'd13, 4'd1, 4'd2));
        load(4'd3, make_instr(OP_SL, 4'd11, 4'd14, 4'd2));
        push(4'd0, 32'h0000_0003);
        push(4'd1, 32'h0000_0001);
        push(4'd2, 32'h0000_0001);
        push(4'd3, 32'h0000_0038);
        run(5'd4);
        wait_done(400);

        // 4: backpressure with start/prog_we attempts during the run
        load(4'd0, make_instr(OP_SUB, 4'd6, 4'd1, 4'd2));
        load(4'd1, make_instr(OP_SL, 4'd7, 4'd14, 4'd15));
        push(4'd0, 32'hFFFF_FFFF);
        push(4'd1, 32'h0007_0000);
        res_ready = 1'b0;
        bt0 = btn_rises;
        run(5'd2);
        k = 0;
        while (!res_valid && k < 100) begin @(negedge clk); k++; end
        check("t4_valid_seen", 32'(res_valid), 32'd1);
        d0 = res_data; s0 = sw; stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            start   = (i == 2);
            prog_len = 5'd1;
            prog_we = (i == 5);
            prog_addr = 4'd1;
            prog_data = make_instr(OP_ADD, 4'd0, 4'd0, 4'd0);
            if (!res_valid || res_data !== d0 || sw !== s0 || btn_exec) stable = 1'b0;
        end
        @(negedge clk);
        start = 1'b0; prog_we = 1'b0;
        check("t4_hold_stable", 32'(stable), 32'd1);
        check("t4_busy_hold", 32'(busy), 32'd1);
        res_ready = 1'b1;
        wait_done(300);
        check("t4_btn_count", 32'(btn_rises - bt0), 32'd2);

        // 6: reset during PULSE, then replay the same program from idx 0
        run(5'd2);
        k = 0;
        while (!btn_exec && k < 50) begin @(negedge clk); k++; end
        check("t6_in_pulse", 32'(btn_exec), 32'd1);
        #2 btn_reset_n = 1'b0;
        #1;
        check("t6_async_ctrl", {25'd0, btn_exec, res_valid, busy, done, 3'd0}, 32'd0);
        check("t6_async_sw", 32'(sw), 32'd0);
        check("t6_async_res", res_data | 32'(res_idx), 32'd0);
        @(negedge clk); #2 btn_reset_n = 1'b1;
        push(4'd0, 32'hFFFF_FFFF);
        push(4'd1, 32'h0007_0000);
        run(5'd2);
        wait_done(300);

        // 5: empty program after reset
        pulse_reset();
        bt0 = btn_rises; v0 = valid_rises;
        run(5'd0);
        check("t5_done", 32'(done), 32'd1);
        check("t5_busy", 32'(busy), 32'd0);
        repeat (5) @(negedge clk);
        check("t5_no_btn", 32'(btn_rises - bt0), 32'd0);
        check("t5_no_valid", 32'(valid_rises - v0), 32'd0);

        // 7: oversized length saturates to the full memory depth
        for (int i = 0; i < 16; i++) begin
            load(4'(i), make_instr(OP_OR, 4'd0, 4'(i), 4'(i)));
            push(4'(i), 32'(i));
        end
        bt0 = btn_rises;
        run(5'd31);
        check("t7_done_cleared", 32'(done), 32'd0);
        check("t7_busy", 32'(busy), 32'd1);
        wait_done(1000);
        check("t7_btn_count", 32'(btn_rises - bt0), 32'd16);

        repeat (3) @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'd0);
        check("sw_change_during_pulse", 32'(viol), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
